// File: rtl/apple1_term_pkg.sv
// Shared types and constants for the Apple-1 video terminal write path.
package apple1_term_pkg;

  localparam int DEFAULT_COLS = 40;
  localparam int DEFAULT_ROWS = 24;

  localparam logic [6:0] ASCII_CR  = 7'h0D;
  localparam logic [6:0] ASCII_DEL = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT_SLOT,
    ST_WRITE,
    ST_NEWLINE,
    ST_WAIT_VBL,
    ST_RELEASE,
    ST_CLEAR
  } wr_state_t;

  // Codes 00..1F are control characters and DEL has no glyph.
  function automatic logic is_printable(input logic [6:0] c);
    return (c[6:5] != 2'b00) && (c != ASCII_DEL);
  endfunction

endpackage

// File: rtl/cursor_pos_counter.sv
// Cursor column/row registers for the character write sequencer.
module cursor_pos_counter
  import apple1_term_pkg::*;
#(
  parameter int COLS = DEFAULT_COLS,
  parameter int ROWS = DEFAULT_ROWS
) (
  input  logic       cp,
  input  logic       mr,
  input  logic       adv,
  input  logic       newline,
  input  logic       clear,
  output logic [5:0] col,
  output logic [4:0] row,
  output logic       last_col,
  output logic       last_row
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  assign last_col = (col == LAST_COL);
  assign last_row = (row == LAST_ROW);

  // On the bottom line a newline only returns the column; the scroll keeps the row.
  always_ff @(posedge cp) begin
    if (mr) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (newline) begin
      col <= '0;
      if (!last_row) row <= row + 5'd1;
    end else if (adv) begin
      col <= col + 6'd1;
    end
  end

endmodule

// File: rtl/apple1_char_write_ctrl.sv
// Apple-1 character write sequencer: PIA handshake, cursor tracking, scroll/clear requests.
// Optional build macro APPLE1_LOWERCASE_FOLD_EN folds 7'h60..7'h7E onto uppercase glyphs.
module apple1_char_write_ctrl
  import apple1_term_pkg::*;
#(
  parameter int COLS = DEFAULT_COLS,
  parameter int ROWS = DEFAULT_ROWS
) (
  input  logic       cp,
  input  logic       mr,
  input  logic       da,
  input  logic [6:0] d,
  output logic       rda,
  input  logic       slot,
  input  logic       vbl,
  input  logic       clr,
  output logic       wr_en,
  output logic [5:0] wr_data,
  output logic       scroll_req,
  output logic       clr_req,
  output logic [5:0] cur_col,
  output logic [4:0] cur_row
);

  wr_state_t  state, next_state;
  logic [6:0] c_q;
  logic [5:0] disp_code;
  logic       adv, newline, clear, last_col, last_row;

  cursor_pos_counter #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .cp       (cp),
    .mr       (mr),
    .adv      (adv),
    .newline  (newline),
    .clear    (clear),
    .col      (cur_col),
    .row      (cur_row),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_comb begin
    disp_code = c_q[5:0];
`ifdef APPLE1_LOWERCASE_FOLD_EN
    if (c_q >= 7'h60 && c_q <= 7'h7E) disp_code = c_q[5:0] & 6'h1F;
`endif
  end

  always_comb begin
    next_state = state;
    adv        = 1'b0;
    newline    = 1'b0;
    clear      = 1'b0;
    case (state)
      ST_IDLE:      if (da) next_state = ST_DECODE;
      ST_DECODE: begin
        if (is_printable(c_q))  next_state = ST_WAIT_SLOT;
        else if (c_q == ASCII_CR) next_state = ST_NEWLINE;
        else                      next_state = ST_RELEASE;
      end
      ST_WAIT_SLOT: if (slot) next_state = ST_WRITE;
      ST_WRITE: begin
        if (last_col) next_state = ST_NEWLINE;
        else begin
          adv        = 1'b1;
          next_state = ST_RELEASE;
        end
      end
      ST_NEWLINE: begin
        newline    = 1'b1;
        next_state = last_row ? ST_WAIT_VBL : ST_RELEASE;
      end
      ST_WAIT_VBL:  if (vbl) next_state = ST_RELEASE;
      ST_RELEASE:   if (!da) next_state = ST_IDLE;
      ST_CLEAR: begin
        if (vbl) begin
          clear      = 1'b1;
          next_state = ST_RELEASE;
        end
      end
      default:      next_state = ST_IDLE;
    endcase
    // A clear request abandons whatever is in flight; repeats while clearing are absorbed.
    if (clr && state != ST_CLEAR) begin
      next_state = ST_CLEAR;
      adv        = 1'b0;
      newline    = 1'b0;
      clear      = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge cp) begin
    if (mr) begin
      state      <= ST_IDLE;
      c_q        <= '0;
      rda        <= 1'b1;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      scroll_req <= 1'b0;
      clr_req    <= 1'b0;
    end else begin
      state      <= next_state;
      rda        <= (next_state == ST_IDLE);
      wr_en      <= (next_state == ST_WRITE);
      scroll_req <= (state == ST_WAIT_VBL) && (next_state == ST_RELEASE);
      clr_req    <= (state == ST_CLEAR) && (next_state == ST_RELEASE);
      if (next_state == ST_WRITE) wr_data <= disp_code;
      if (state == ST_IDLE && da) c_q <= d;
    end
  end

endmodule

// File: tb/tb_apple1_char_write_ctrl.sv
// Randomized self-checking bench for apple1_char_write_ctrl against a cursor/terminal model.
module tb_apple1_char_write_ctrl;

  logic       cp = 1'b0;
  logic       mr, da, slot, vbl, clr;
  logic [6:0] d;
  logic       rda, wr_en, scroll_req, clr_req;
  logic [5:0] wr_data, cur_col;
  logic [4:0] cur_row;

  int checks   = 0;
  int failures = 0;
  int m_col    = 0;
  int m_row    = 0;
  int total_wr = 0;
  int total_scroll = 0;

  apple1_char_write_ctrl #(.COLS(40), .ROWS(24)) dut (
    .cp(cp), .mr(mr), .da(da), .d(d), .rda(rda), .slot(slot), .vbl(vbl), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .scroll_req(scroll_req), .clr_req(clr_req),
    .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 cp = ~cp;

  task automatic tick;
    @(posedge cp);
    #1;
  endtask

  function automatic bit ref_printable(input logic [6:0] c);
    return (int'(c) >= 32) && (int'(c) != 127);
  endfunction

  function automatic logic [5:0] ref_code(input logic [6:0] c);
    int v;
    v = int'(c) % 64;
`ifdef APPLE1_LOWERCASE_FOLD_EN
    if (int'(c) >= 96 && int'(c) <= 126) v = v - 32;
`endif
    return 6'(v);
  endfunction

  // Full handshake for one byte with random slot/vbl pulses; checks against the model.
  task automatic send_byte(input logic [6:0] c);
    int exp_wr, exp_scroll, wr_cnt, scroll_cnt, cyc;
    logic [5:0] exp_code, got_code;
    bit done;
    exp_wr = 0; exp_scroll = 0; wr_cnt = 0; scroll_cnt = 0; cyc = 0; done = 0;
    exp_code = ref_code(c); got_code = '0;
    if (ref_printable(c)) begin
      exp_wr = 1;
      if (m_col < 39) m_col++;
      else begin
        m_col = 0;
        if (m_row < 23) m_row++; else exp_scroll = 1;
      end
    end else if (c == 7'h0D) begin
      m_col = 0;
      if (m_row < 23) m_row++; else exp_scroll = 1;
    end
    while (rda !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    checks++;
    if (rda !== 1'b1) begin
      failures++;
      $display("[TB] FAIL send_rda_idle c=%h rda=%b required 1", c, rda);
    end
    da = 1'b1; d = c;
    tick();
    da = 1'b0; d = 7'($urandom);
    cyc = 0;
    while (!done && cyc < 300) begin
      slot = ($urandom_range(0, 3) == 0);
      vbl  = ($urandom_range(0, 7) == 0);
      tick();
      slot = 1'b0; vbl = 1'b0;
      if (wr_en === 1'b1) begin wr_cnt++; got_code = wr_data; end
      if (scroll_req === 1'b1) scroll_cnt++;
      if (rda === 1'b1) done = 1;
      cyc++;
    end
    total_wr += wr_cnt;
    total_scroll += scroll_cnt;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL send_timeout c=%h rda=%b required 1 within 300 cycles", c, rda);
    end
    checks++;
    if (wr_cnt != exp_wr) begin
      failures++;
      $display("[TB] FAIL send_wr_count c=%h got %0d required %0d", c, wr_cnt, exp_wr);
    end
    if (exp_wr == 1) begin
      checks++;
      if (got_code !== exp_code) begin
        failures++;
        $display("[TB] FAIL send_wr_data c=%h got %h required %h", c, got_code, exp_code);
      end
    end
    checks++;
    if (scroll_cnt != exp_scroll) begin
      failures++;
      $display("[TB] FAIL send_scroll c=%h got %0d required %0d", c, scroll_cnt, exp_scroll);
    end
    checks++;
    if (cur_col !== 6'(m_col) || cur_row !== 5'(m_row)) begin
      failures++;
      $display("[TB] FAIL send_cursor c=%h got (%0d,%0d) required (%0d,%0d)",
               c, cur_col, cur_row, m_col, m_row);
    end
  endtask

  task automatic do_reset;
    mr = 1'b1;
    tick();
    mr = 1'b0;
    m_col = 0; m_row = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (rda !== 1'b1 || wr_en !== 1'b0 || wr_data !== 6'h00 || scroll_req !== 1'b0 ||
        clr_req !== 1'b0 || cur_col !== 6'd0 || cur_row !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got rda=%b wr_en=%b wr_data=%h scroll=%b clr_req=%b col=%0d row=%0d required 1,0,00,0,0,0,0",
               rda, wr_en, wr_data, scroll_req, clr_req, cur_col, cur_row);
    end
  endtask

  task automatic test_single_char;
    bit rda_early;
    rda_early = 0;
    da = 1'b1; d = 7'h41;
    tick();
    tick();
    slot = 1'b1;
    tick();
    slot = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 6'h01) begin
      failures++;
      $display("[TB] FAIL single_write got wr_en=%b wr_data=%h required 1,01", wr_en, wr_data);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0 || cur_col !== 6'd1 || cur_row !== 5'd0) begin
      failures++;
      $display("[TB] FAIL single_after got wr_en=%b col=%0d row=%0d required 0,1,0", wr_en, cur_col, cur_row);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rda !== 1'b0) rda_early = 1;
    end
    checks++;
    if (rda_early) begin
      failures++;
      $display("[TB] FAIL single_rda_held rda rose while da=1, required 0");
    end
    da = 1'b0;
    tick();
    checks++;
    if (rda !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_rda_release got %b required 1", rda);
    end
    m_col = 1; m_row = 0;
  endtask

  task automatic test_full_line;
    int wr_before, scroll_before;
    do_reset();
    wr_before = total_wr; scroll_before = total_scroll;
    for (int i = 0; i < 40; i++) send_byte(7'($urandom_range(32, 126)));
    checks++;
    if (total_wr - wr_before != 40 || total_scroll != scroll_before) begin
      failures++;
      $display("[TB] FAIL full_line_counts got wr=%0d scroll=%0d required 40,0",
               total_wr - wr_before, total_scroll - scroll_before);
    end
    checks++;
    if (cur_col !== 6'd0 || cur_row !== 5'd1) begin
      failures++;
      $display("[TB] FAIL full_line_cursor got (%0d,%0d) required (0,1)", cur_col, cur_row);
    end
  endtask

  task automatic test_scroll;
    bit early;
    early = 0;
    do_reset();
    for (int i = 0; i < 23; i++) send_byte(7'h0D);
    da = 1'b1; d = 7'h0D;
    tick();
    da = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (scroll_req !== 1'b0 || rda !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("[TB] FAIL scroll_early scroll_req or rda rose before vbl, required 0");
    end
    vbl = 1'b1;
    tick();
    vbl = 1'b0;
    checks++;
    if (scroll_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL scroll_pulse got %b required 1", scroll_req);
    end
    tick();
    checks++;
    if (scroll_req !== 1'b0 || rda !== 1'b1 || cur_row !== 5'd23 || cur_col !== 6'd0) begin
      failures++;
      $display("[TB] FAIL scroll_after got scroll=%b rda=%b row=%0d col=%0d required 0,1,23,0",
               scroll_req, rda, cur_row, cur_col);
    end
    m_col = 0; m_row = 23;
  endtask

  task automatic test_reset_mid_wait_vbl;
    da = 1'b1; d = 7'h0D;
    tick();
    da = 1'b0;
    tick(); tick(); tick();
    mr = 1'b1;
    tick();
    mr = 1'b0;
    checks++;
    if (rda !== 1'b1 || wr_en !== 1'b0 || wr_data !== 6'h00 || scroll_req !== 1'b0 ||
        clr_req !== 1'b0 || cur_col !== 6'd0 || cur_row !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_vbl got rda=%b wr_en=%b wr_data=%h scroll=%b clr_req=%b col=%0d row=%0d required 1,0,00,0,0,0,0",
               rda, wr_en, wr_data, scroll_req, clr_req, cur_col, cur_row);
    end
    m_col = 0; m_row = 0;
  endtask

  task automatic test_nonprint;
    send_byte(7'h41);
    send_byte(7'h07);
    send_byte(7'h7F);
    send_byte(7'h00);
  endtask

  task automatic test_lowercase;
    send_byte(7'h61);
    send_byte(7'h7E);
    send_byte(7'h5A);
  endtask

  task automatic clear_tail(input string tag);
    bit bad;
    bad = 0;
    slot = 1'b1;
    tick();
    slot = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wr_en !== 1'b0 || clr_req !== 1'b0) bad = 1;
    end
    if (wr_en !== 1'b0) bad = 1;
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL %s_premature saw wr_en or clr_req before vbl, required 0", tag);
    end
    vbl = 1'b1;
    tick();
    vbl = 1'b0;
    checks++;
    if (clr_req !== 1'b1 || wr_en !== 1'b0 || cur_col !== 6'd0 || cur_row !== 5'd0) begin
      failures++;
      $display("[TB] FAIL %s_pulse got clr_req=%b wr_en=%b col=%0d row=%0d required 1,0,0,0",
               tag, clr_req, wr_en, cur_col, cur_row);
    end
    tick();
    checks++;
    if (clr_req !== 1'b0 || rda !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_after got clr_req=%b rda=%b required 0,1", tag, clr_req, rda);
    end
    m_col = 0; m_row = 0;
  endtask

  task automatic test_clear;
    send_byte(7'h41);
    send_byte(7'h0D);
    send_byte(7'h42);
    da = 1'b1; d = 7'h43;
    tick();
    da = 1'b0;
    tick();
    clr = 1'b1; da = 1'b1; d = 7'h44;
    tick();
    clr = 1'b0; da = 1'b0;
    clear_tail("clear_wait_slot");
    send_byte(7'h45);
    clr = 1'b1; da = 1'b1; d = 7'h46;
    tick();
    clr = 1'b0; da = 1'b0;
    clear_tail("clear_idle_da");
  endtask

  task automatic test_random;
    logic [6:0] c;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: c = 7'($urandom_range(32, 126));
        3:       c = 7'h0D;
        default: c = 7'($urandom_range(0, 127));
      endcase
      send_byte(c);
    end
  endtask

  initial begin
    mr = 1'b0; da = 1'b0; d = '0; slot = 1'b0; vbl = 1'b0; clr = 1'b0;
    tick();
    test_reset();
    test_single_char();
    test_full_line();
    test_scroll();
    test_reset_mid_wait_vbl();
    test_nonprint();
    test_lowercase();
    test_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
